// File: rtl/axis_flit_injector.sv
// AXI-Stream to NoC flit injector: holds one beat, serializes it LSB-slice first into flits and
// paces them against a downstream credit counter, with optional per-packet destination locking.
module axis_flit_injector #(
    parameter int unsigned TDATA_WIDTH          = 128,
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned SERIALIZATION_FACTOR = 2,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 2,
    parameter int unsigned DEST_FROM_FIRST_BEAT = 1,
    parameter int unsigned FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int unsigned DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int unsigned CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic                    axis_in_tvalid,
    output logic                    axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]  axis_in_tdata,
    input  logic                    axis_in_tlast,
    input  logic [TID_WIDTH-1:0]    axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]  axis_in_tdest,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    pkt_active,
    output logic                    err_credit_overflow
);

    localparam int unsigned IdxW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(SERIALIZATION_FACTOR - 1);
    localparam logic [CREDIT_WIDTH-1:0] CreditMax = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CreditOne = CREDIT_WIDTH'(1);

    logic                    hold_valid_q, hold_valid_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [TDATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic                    hold_last_q, hold_last_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic                    pkt_active_q, pkt_active_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic                    err_q, err_d;
    logic [FLIT_WIDTH-1:0]   data_out_q, data_out_d;
    logic [DEST_WIDTH-1:0]   dest_out_q, dest_out_d;
    logic                    tail_q, tail_d;
    logic                    send_q, send_d;

    logic have_credit, last_slice, issue, accept;
    logic [FLIT_WIDTH-1:0] slice;

    assign have_credit = (credits_q != '0);
    assign last_slice  = (idx_q == IdxLast);
    assign issue       = hold_valid_q && have_credit;
    // Ready depends only on registered state (and reset), never on tvalid.
    assign axis_in_tready = !rst_noc_sync && (!hold_valid_q || (last_slice && have_credit));
    assign accept         = axis_in_tvalid && axis_in_tready;
    assign slice          = hold_data_q[32'(idx_q) * FLIT_WIDTH +: FLIT_WIDTH];

    always_comb begin
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        dest_d       = dest_q;
        pkt_active_d = pkt_active_q;
        credits_d    = credits_q;
        err_d        = err_q;
        data_out_d   = data_out_q;
        dest_out_d   = dest_out_q;
        tail_d       = tail_q;
        send_d       = 1'b0;

        if (issue) begin
            data_out_d = slice;
            dest_out_d = dest_q;
            tail_d     = hold_last_q && last_slice;
            send_d     = 1'b1;
            if (last_slice) begin
                hold_valid_d = 1'b0;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end

        // A reload on the final-slice edge overrides the clear above.
        if (accept) begin
            hold_valid_d = 1'b1;
            idx_d        = '0;
            hold_data_d  = axis_in_tdata;
            hold_last_d  = axis_in_tlast;
            pkt_active_d = !axis_in_tlast;
            if (DEST_FROM_FIRST_BEAT == 0 || !pkt_active_q) begin
                dest_d = {axis_in_tid, axis_in_tdest};
            end
        end

        case ({issue, credit_in})
            2'b10: credits_d = credits_q - CreditOne;
            2'b01: begin
                if (credits_q == CreditMax) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CreditOne;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            hold_valid_q <= 1'b0;
            idx_q        <= '0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            dest_q       <= '0;
            pkt_active_q <= 1'b0;
            credits_q    <= CreditMax;
            err_q        <= 1'b0;
            data_out_q   <= '0;
            dest_out_q   <= '0;
            tail_q       <= 1'b0;
            send_q       <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            dest_q       <= dest_d;
            pkt_active_q <= pkt_active_d;
            credits_q    <= credits_d;
            err_q        <= err_d;
            data_out_q   <= data_out_d;
            dest_out_q   <= dest_out_d;
            tail_q       <= tail_d;
            send_q       <= send_d;
        end
    end

    assign data_out            = data_out_q;
    assign dest_out            = dest_out_q;
    assign is_tail_out         = tail_q;
    assign send_out            = send_q;
    assign credits_avail       = credits_q;
    assign pkt_active          = pkt_active_q;
    assign err_credit_overflow = err_q;

endmodule

// File: tb/tb_axis_flit_injector.sv
// Bench for axis_flit_injector: directed scenarios plus random traffic, all checked every cycle
// against a flit-queue reference model of the injector.
module tb_axis_flit_injector;

    localparam int TW = 128, SF = 2, FW = 64, DW = 6, DEPTH = 2, CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          tvalid = 1'b0, tready, tlast = 1'b0, credit_in = 1'b0;
    logic [TW-1:0] tdata = '0;
    logic [1:0]    tid = '0;
    logic [3:0]    tdest = '0;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out, send_out, pkt_active, err_ovf;
    logic [CW-1:0] credits_avail;

    axis_flit_injector dut (
        .clk_noc(clk), .rst_noc_sync(rst),
        .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
        .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in), .credits_avail(credits_avail),
        .pkt_active(pkt_active), .err_credit_overflow(err_ovf)
    );

    typedef struct packed {logic [TW-1:0] d; logic last; logic [1:0] id; logic [3:0] dst;} beat_t;
    typedef struct packed {logic [FW-1:0] d; logic [DW-1:0] dst; logic tail;} flit_t;

    beat_t src[$];          // beats waiting to be offered
    flit_t mq[$];           // model: flits accepted but not yet sent
    int    m_cr = DEPTH;
    bit    m_pkt, m_err, m_send, presenting;
    flit_t m_out = '0;
    logic [DW-1:0] m_lock = '0;
    int    gap_pct = 0;     // chance of idling tvalid between beats
    int    n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit r);
        return !r && (mq.size() == 0 || (mq.size() == 1 && m_cr > 0));
    endfunction

    task automatic compare();
        check("tready", 128'(tready), 128'(model_ready(rst)));
        check("send_out", 128'(send_out), 128'(m_send));
        check("data_out", 128'(data_out), 128'(m_out.d));
        check("dest_out", 128'(dest_out), 128'(m_out.dst));
        check("is_tail", 128'(is_tail_out), 128'(m_out.tail));
        check("credits", 128'(credits_avail), 128'(m_cr));
        check("pkt_active", 128'(pkt_active), 128'(m_pkt));
        check("err_ovf", 128'(err_ovf), 128'(m_err));
    endtask

    // One clock: compare current outputs, drive inputs, advance the model over the coming edge.
    task automatic step(input bit cin, input bit r, input bit do_cmp = 1'b1);
        bit rdy, iss, acc;
        beat_t b;
        flit_t f;
        if (do_cmp) compare();
        rdy = model_ready(r);
        b = (src.size() > 0) ? src[0] : beat_t'({$urandom, $urandom, $urandom, $urandom, 8'($urandom)});
        tvalid    = (src.size() > 0) && (presenting || $urandom_range(99) >= gap_pct);
        tdata     = b.d;
        tlast     = b.last;
        tid       = b.id;
        tdest     = b.dst;
        credit_in = cin;
        rst       = r;
        acc = tvalid && rdy;
        presenting = tvalid && !acc && !r;
        if (r) begin
            mq.delete();
            m_cr = DEPTH; m_pkt = 0; m_err = 0; m_send = 0; m_out = '0; m_lock = '0;
        end else begin
            iss = (mq.size() > 0) && (m_cr > 0);
            m_send = iss;
            if (iss) m_out = mq.pop_front();
            if (cin && !iss) begin
                if (m_cr == DEPTH) m_err = 1;
                else m_cr++;
            end else if (iss && !cin) begin
                m_cr--;
            end
            if (acc) begin
                void'(src.pop_front());
                if (!m_pkt) m_lock = {b.id, b.dst};
                m_pkt = !b.last;
                for (int i = 0; i < SF; i++) begin
                    f.d = b.d[i*FW +: FW];
                    f.dst = m_lock;
                    f.tail = b.last && (i == SF - 1);
                    mq.push_back(f);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((src.size() > 0 || mq.size() > 0 || m_cr < DEPTH) && n < 400) begin
            step(bit'(m_cr < DEPTH && $urandom_range(99) < 60), 1'b0);
            n++;
        end
        check(tag, 128'(src.size() + mq.size()), 128'd0);
    endtask

    task automatic push(input logic [TW-1:0] d, input bit last, input logic [1:0] id,
                        input logic [3:0] dst);
        beat_t b;
        b.d = d; b.last = last; b.id = id; b.dst = dst;
        src.push_back(b);
    endtask

    initial begin
        int n;
        @(negedge clk);
        // Reset held three cycles, then first post-reset cycle must show tready.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("reset_credits", 128'(credits_avail), 128'(DEPTH));

        // Single beat, no credit return: two flits, credits 2 -> 0.
        push({{16{4'hA}}, {16{4'h5}}}, 1'b1, 2'b01, 4'h5);
        repeat (5) step(1'b0, 1'b0);
        check("single_credits", 128'(credits_avail), 128'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Starvation: three beats, no credits, then a single credit pulse.
        for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd2, 4'(i));
        repeat (8) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        drain("starve_drain");

        // Credit returned on the same edge as a send with one credit left.
        push({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd3, 4'hC);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        drain("simul_drain");

        // Overflow with full credits is sticky until reset.
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check("ovf_sticky", 128'(err_ovf), 128'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Dest lock across a three-beat packet followed by a single-beat packet.
        push({$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'd0, 4'd5);
        push({$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'd0, 4'd9);
        push({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd0, 4'd9);
        push({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd0, 4'd9);
        drain("lock_drain");

        // Reset right after the first flit of an open packet.
        push({$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'd1, 4'd7);
        push({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd1, 4'd8);
        n = 0;
        while (!m_send && n < 10) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("midpkt_first_flit", 128'(m_send), 128'd1);
        src.delete();
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // Random traffic with gaps, backpressure and occasional spurious credits.
        for (int round = 0; round < 4; round++) begin
            gap_pct = 25 * round;
            for (int i = 0; i < 25; i++)
                push({$urandom, $urandom, $urandom, $urandom}, bit'($urandom_range(2) == 0),
                     2'($urandom), 4'($urandom));
            n = 0;
            while ((src.size() > 0 || mq.size() > 0) && n < 600) begin
                step(bit'((m_cr < DEPTH && $urandom_range(99) < 45) || $urandom_range(99) < 2),
                     1'b0);
                n++;
            end
            check("random_drain", 128'(src.size() + mq.size()), 128'd0);
            src.delete();
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
